trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
// - Multi-cycle controller that owns the single CSR write port in the writeback stage.
// - On a trap (WB_CS from the trap handler) it sequences writes to mepc, mcause, mtval and mstatus, then flushes and redirects fetch to mtvec.
// - On MRET it restores mstatus and privilege, then redirects to mepc.
// - When idle it grants the port to CSR-instruction writes.
// PARAMETERS
// - XLEN       64  datapath width.
// - VECTOR_EN  1   1: honour mtvec MODE=1 (vectored) for interrupts; 0: always direct.
// - TVAL_EN    1   1: write mtval state; 0: skip the SAVE_TVAL state (one cycle shorter).
// PORTS
// - CLK          in   1     clock, rising edge.
// - RESET        in   1     asynchronous, active-low reset.
// - TRAP_REQ     in   1     trap pending (WB_CS); held until TRAP_ACK.
// - TRAP_CAUSE   in   XLEN  mcause value; bit XLEN-1 = interrupt.
// - TRAP_PC      in   XLEN  PC of trapping instruction.
// - TRAP_TVAL    in   XLEN  faulting address/instruction.
// - MRET_REQ     in   1     MRET retiring in WB; held until MRET_ACK.
// - PRIVILEGE    in   2     current privilege.
// - MTVEC        in   XLEN  current mtvec.
// - MEPC         in   XLEN  current mepc.
// - MSTATUS      in   XLEN  current mstatus.
// - CSR_WR_REQ   in   1     CSR-instruction write request.
// - CSR_WR_ADDR  in   12    its address.
// - CSR_WR_DATA  in   XLEN  its data.
// - CSR_WE       out  1     CSR file write enable.
// - CSR_WADDR    out  12    CSR file write address.
// - CSR_WDATA    out  XLEN  CSR file write data.
// - CSR_WR_ACK   out  1     instruction write performed this cycle.
// - TRAP_ACK     out  1     one-cycle pulse: trap accepted.
// - MRET_ACK     out  1     one-cycle pulse: MRET accepted.
// - FLUSH        out  1     one-cycle pulse: kill all younger pipeline stages.
// - STALL        out  1     hold fetch..WB; equals BUSY.
// - BUSY         out  1     sequencer not in IDLE.
// - REDIRECT_V   out  1     one-cycle pulse: load REDIRECT_PC into the PC.
// - REDIRECT_PC  out  XLEN  new fetch PC.
// - PRIV_OUT     out  2     privilege after trap/MRET (registered).
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0 except PRIV_OUT=2'b11. Reset mid-sequence aborts it; no further CSR writes occur.
// - States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, MRET_STATUS, REDIRECT.
// - IDLE priority: TRAP_REQ > MRET_REQ > CSR_WR_REQ.
// - Trap accept (cycle N, IDLE): TRAP_ACK=1; latch CAUSE/PC/TVAL/PRIVILEGE/MTVEC; no CSR write.
//   - N+1 SAVE_EPC: FLUSH=1; WE=1, addr 0x341, data {PC[XLEN-1:2],2'b00}.
//   - N+2 SAVE_CAUSE: addr 0x342, data CAUSE.
//   - N+3 SAVE_TVAL: addr 0x343, data TVAL (state skipped if TVAL_EN=0).
//   - N+4 SAVE_STATUS: addr 0x300; data = MSTATUS sampled that cycle with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=latched PRIVILEGE.
//   - N+5 REDIRECT: REDIRECT_V=1; PRIV_OUT<=2'b11; next IDLE.
// - Trap target: base={MTVEC[XLEN-1:2],2'b00}. If VECTOR_EN && MTVEC[1:0]==1 && CAUSE[XLEN-1], target = base + 4*CAUSE[5:0]; otherwise target = base. MTVEC[1:0]>=2 is treated as direct. Adds wrap modulo 2^XLEN.
// - MRET accept (cycle N): MRET_ACK=1; latch MEPC.
//   - N+1 MRET_STATUS: FLUSH=1; addr 0x300; MIE=MPIE, MPIE=1, MPP=2'b00; PRIV_OUT<=old MPP.
//   - N+2 REDIRECT: REDIRECT_PC=latched MEPC.
// - CSR-instruction path: in IDLE with no TRAP_REQ/MRET_REQ, CSR_WE/ADDR/DATA pass CSR_WR_* through combinationally and CSR_WR_ACK=CSR_WR_REQ (0 latency).
//   - While BUSY, or on a cycle a trap/MRET is accepted, CSR_WR_ACK=0; the request is either flushed or held.
// - TRAP_REQ/MRET_REQ while BUSY: ignored, not queued; the source holds. A trap re-asserted in REDIRECT is accepted on the following IDLE cycle.
// - BUSY=STALL=1 exactly while state!=IDLE. CSR_WE is never asserted in IDLE except on the grant path.
// - CSR_WADDR/CSR_WDATA are 0 whenever CSR_WE=0.
// TESTING
// - Exception: PRIVILEGE=0, CAUSE=2, PC=0x8000_0104, TVAL=0x13, MTVEC=0x8000_0001, MSTATUS=0x8 -> writes 0x341<=0x80000104, 0x342<=2, 0x343<=0x13, 0x300<=0x80 on N+1..N+4; REDIRECT_PC=0x8000_0000 at N+5; PRIV_OUT=3.
// - Interrupt: CAUSE=(1<<63)|7, MTVEC=0x8000_0001 -> REDIRECT_PC=0x8000_001C; same target=0x8000_0000 with VECTOR_EN=0.
// - MRET: MSTATUS=0x880 (MPP=1, MPIE=1), MEPC=0x400 -> N+1 0x300<=0x88; PRIV_OUT=1; N+2 REDIRECT_PC=0x400.
// - Arbitration: TRAP_REQ and CSR_WR_REQ(0x305, 0x100) together -> TRAP_ACK=1, CSR_WR_ACK=0; CSR_WR_REQ alone while BUSY -> no write until IDLE, then same-cycle ack.
// - RESET low at N+2 of trap sequence -> all outputs 0, PRIV_OUT=3 immediately; no 0x343/0x300 write; after release TRAP_REQ held -> sequence restarts.
// - TVAL_EN=0 -> REDIRECT at N+4, no 0x343 write.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// ---------------------------------------------------------------------------
// trap_sequencer_if
// Bundle between the writeback stage / CSR file and the trap sequencer.
//   master : pipeline side, drives trap/MRET/CSR-write requests and the
//            current CSR values, observes the CSR write port and the control
//            pulses.
//   slave  : the sequencer itself.
// Request side : trap_req, trap_cause, trap_pc, trap_tval, mret_req,
//                privilege, mtvec, mepc, mstatus, csr_wr_req, csr_wr_addr,
//                csr_wr_data
// Result side  : csr_we, csr_waddr, csr_wdata, csr_wr_ack, trap_ack,
//                mret_ack, flush, stall, busy, redirect_v, redirect_pc,
//                priv_out
// ---------------------------------------------------------------------------
interface trap_sequencer_if #(
    parameter int unsigned XLEN = 64
);
    // Requests and current architectural state
    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            mret_req;
    logic [1:0]      privilege;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mstatus;
    logic            csr_wr_req;
    logic [11:0]     csr_wr_addr;
    logic [XLEN-1:0] csr_wr_data;

    // CSR write port and pipeline control
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_wr_ack;
    logic            trap_ack;
    logic            mret_ack;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            redirect_v;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      priv_out;

    modport master (
        output trap_req, trap_cause, trap_pc, trap_tval, mret_req, privilege,
               mtvec, mepc, mstatus, csr_wr_req, csr_wr_addr, csr_wr_data,
        input  csr_we, csr_waddr, csr_wdata, csr_wr_ack, trap_ack, mret_ack,
               flush, stall, busy, redirect_v, redirect_pc, priv_out
    );

    modport slave (
        input  trap_req, trap_cause, trap_pc, trap_tval, mret_req, privilege,
               mtvec, mepc, mstatus, csr_wr_req, csr_wr_addr, csr_wr_data,
        output csr_we, csr_waddr, csr_wdata, csr_wr_ack, trap_ack, mret_ack,
               flush, stall, busy, redirect_v, redirect_pc, priv_out
    );
endinterface

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
// Owns the single CSR write port in writeback. A trap is sequenced as writes
// to mepc, mcause, (mtval), mstatus followed by a fetch redirect to mtvec;
// MRET restores mstatus/privilege and redirects to mepc. In IDLE the port is
// handed to CSR-instruction writes with zero latency.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : trap_sequencer_if.slave (requests in, CSR port / control out)
// Parameters:
//   XLEN      : datapath width (>= 13)
//   VECTOR_EN : honour vectored mtvec for interrupts
//   TVAL_EN   : include the mtval write
// ---------------------------------------------------------------------------
module trap_sequencer #(
    parameter int unsigned XLEN      = 64,
    parameter bit          VECTOR_EN = 1'b1,
    parameter bit          TVAL_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    trap_sequencer_if.slave  bus
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [1:0]  PRIV_M      = 2'b11;
    localparam logic [1:0]  PRIV_U      = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_SAVE_TVAL,
        ST_SAVE_STATUS,
        ST_MRET_STATUS,
        ST_REDIRECT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [1:0]      priv_q, priv_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            is_trap_q, is_trap_d;
    logic [1:0]      priv_out_q, priv_out_d;

    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_wr_ack;
    logic            trap_ack;
    logic            mret_ack;
    logic            flush;
    logic            redirect_v;
    logic [XLEN-1:0] redirect_pc;

    // mstatus on trap entry: MPIE<=MIE, MIE<=0, MPP<=privilege at the trap
    function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] ms,
                                                    input logic [1:0]      pp);
        logic [XLEN-1:0] s;
        s        = ms;
        s[7]     = ms[3];
        s[3]     = 1'b0;
        s[12:11] = pp;
        return s;
    endfunction

    // mstatus on MRET: MIE<=MPIE, MPIE<=1, MPP<=U
    function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] s;
        s        = ms;
        s[3]     = ms[7];
        s[7]     = 1'b1;
        s[12:11] = PRIV_U;
        return s;
    endfunction

    // Trap vector: vectored only for interrupts with MODE=1; MODE>=2 is direct
    function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                    input logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = {tvec[XLEN-1:2], 2'b00};
        if (VECTOR_EN && (tvec[1:0] == 2'b01) && cause[XLEN-1]) begin
            return base + (XLEN'(cause[5:0]) << 2);
        end
        return base;
    endfunction

    // State and latched-operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cause_q    <= '0;
            epc_q      <= '0;
            tval_q     <= '0;
            priv_q     <= PRIV_U;
            target_q   <= '0;
            is_trap_q  <= 1'b0;
            priv_out_q <= PRIV_M;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            tval_q     <= tval_d;
            priv_q     <= priv_d;
            target_q   <= target_d;
            is_trap_q  <= is_trap_d;
            priv_out_q <= priv_out_d;
        end
    end

    // Next state and CSR-port / control decode
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        tval_d      = tval_q;
        priv_d      = priv_q;
        target_d    = target_q;
        is_trap_d   = is_trap_q;
        priv_out_d  = priv_out_q;

        csr_we      = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;
        csr_wr_ack  = 1'b0;
        trap_ack    = 1'b0;
        mret_ack    = 1'b0;
        flush       = 1'b0;
        redirect_v  = 1'b0;
        redirect_pc = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Request-driven outputs are gated so nothing leaks while in reset
                if (rst_n) begin
                    if (bus.trap_req) begin
                        trap_ack  = 1'b1;
                        cause_d   = bus.trap_cause;
                        epc_d     = {bus.trap_pc[XLEN-1:2], 2'b00};
                        tval_d    = bus.trap_tval;
                        priv_d    = bus.privilege;
                        target_d  = trap_target(bus.mtvec, bus.trap_cause);
                        is_trap_d = 1'b1;
                        state_d   = ST_SAVE_EPC;
                    end else if (bus.mret_req) begin
                        mret_ack  = 1'b1;
                        target_d  = bus.mepc;
                        is_trap_d = 1'b0;
                        state_d   = ST_MRET_STATUS;
                    end else if (bus.csr_wr_req) begin
                        csr_we     = 1'b1;
                        csr_waddr  = bus.csr_wr_addr;
                        csr_wdata  = bus.csr_wr_data;
                        csr_wr_ack = 1'b1;
                    end
                end
            end
            ST_SAVE_EPC: begin
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = epc_q;
                state_d   = ST_SAVE_CAUSE;
            end
            ST_SAVE_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cause_q;
                state_d   = TVAL_EN ? ST_SAVE_TVAL : ST_SAVE_STATUS;
            end
            ST_SAVE_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = tval_q;
                state_d   = ST_SAVE_STATUS;
            end
            ST_SAVE_STATUS: begin
                // mstatus is taken live so the freshest copy is updated
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = trap_status(bus.mstatus, priv_q);
                state_d   = ST_REDIRECT;
            end
            ST_MRET_STATUS: begin
                flush      = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MSTATUS;
                csr_wdata  = mret_status(bus.mstatus);
                priv_out_d = bus.mstatus[12:11];
                state_d    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_v  = 1'b1;
                redirect_pc = target_q;
                if (is_trap_q) begin
                    priv_out_d = PRIV_M;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.csr_we      = csr_we;
    assign bus.csr_waddr   = csr_waddr;
    assign bus.csr_wdata   = csr_wdata;
    assign bus.csr_wr_ack  = csr_wr_ack;
    assign bus.trap_ack    = trap_ack;
    assign bus.mret_ack    = mret_ack;
    assign bus.flush       = flush;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.stall       = (state_q != ST_IDLE);
    assign bus.redirect_v  = redirect_v;
    assign bus.redirect_pc = redirect_pc;
    assign bus.priv_out    = priv_out_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
// Three sequencers share one stimulus: default parameters, VECTOR_EN=0 and
// TVAL_EN=0. A transaction-level reference model predicts every output of
// every instance on every cycle; directed steps add literal checks for the
// documented examples, then a randomized phase runs with random requests,
// operands and occasional reset pulses.
// ---------------------------------------------------------------------------
module tb_trap_sequencer;

    localparam int unsigned XLEN = 64;
    localparam int          NDUT = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            mret_req;
    logic [1:0]      privilege;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mstatus;
    logic            csr_wr_req;
    logic [11:0]     csr_wr_addr;
    logic [XLEN-1:0] csr_wr_data;

    typedef struct packed {
        logic            we;
        logic [11:0]     addr;
        logic [XLEN-1:0] data;
        logic            wr_ack;
        logic            tack;
        logic            mack;
        logic            flush;
        logic            stall;
        logic            busy;
        logic            rv;
        logic [XLEN-1:0] rpc;
        logic [1:0]      priv;
    } obs_t;

    obs_t obs [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        trap_sequencer_if #(.XLEN(XLEN)) sif ();
        assign sif.trap_req    = trap_req;
        assign sif.trap_cause  = trap_cause;
        assign sif.trap_pc     = trap_pc;
        assign sif.trap_tval   = trap_tval;
        assign sif.mret_req    = mret_req;
        assign sif.privilege   = privilege;
        assign sif.mtvec       = mtvec;
        assign sif.mepc        = mepc;
        assign sif.mstatus     = mstatus;
        assign sif.csr_wr_req  = csr_wr_req;
        assign sif.csr_wr_addr = csr_wr_addr;
        assign sif.csr_wr_data = csr_wr_data;

        trap_sequencer #(
            .XLEN      (XLEN),
            .VECTOR_EN (g != 1),
            .TVAL_EN   (g != 2)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (sif.slave)
        );

        assign obs[g] = '{we: sif.csr_we, addr: sif.csr_waddr, data: sif.csr_wdata,
                          wr_ack: sif.csr_wr_ack, tack: sif.trap_ack, mack: sif.mret_ack,
                          flush: sif.flush, stall: sif.stall, busy: sif.busy,
                          rv: sif.redirect_v, rpc: sif.redirect_pc, priv: sif.priv_out};
    end

    // Reference model state: per instance, which transaction is in flight and
    // how many cycles after its acceptance we are.
    int              mode [NDUT];   // 0 none, 1 trap, 2 mret
    int              kk   [NDUT];
    logic [XLEN-1:0] l_epc    [NDUT];
    logic [XLEN-1:0] l_cause  [NDUT];
    logic [XLEN-1:0] l_tval   [NDUT];
    logic [1:0]      l_priv   [NDUT];
    logic [XLEN-1:0] l_target [NDUT];
    logic [1:0]      priv_m   [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic logic [XLEN-1:0] target_of(bit vec, logic [XLEN-1:0] tv,
                                                  logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = tv & ~64'h3;
        if (vec && ((tv & 64'h3) == 64'h1) && (cause >= 64'h8000_0000_0000_0000))
            return base + (cause & 64'h3F) * 64'd4;
        return base;
    endfunction

    // Busy cycles following acceptance: the writes plus the redirect
    function automatic int seq_len(int d, int m);
        if (m == 1) return (d == 2) ? 4 : 5;
        return 2;
    endfunction

    function automatic logic [XLEN-1:0] trap_mstatus(logic [XLEN-1:0] ms, logic [1:0] pp);
        logic [XLEN-1:0] s;
        s = ms & ~64'h1888;
        if ((ms & 64'h8) != 0) s = s | 64'h80;
        s = s | (XLEN'(pp) << 11);
        return s;
    endfunction

    function automatic logic [XLEN-1:0] mret_mstatus(logic [XLEN-1:0] ms);
        logic [XLEN-1:0] s;
        s = (ms & ~64'h1808) | 64'h80;
        if ((ms & 64'h80) != 0) s = s | 64'h8;
        return s;
    endfunction

    function automatic obs_t expect_of(int d);
        obs_t e;
        int   nw;
        e      = '0;
        e.priv = priv_m[d];
        if (rst_n !== 1'b1) begin
            e.priv = 2'b11;
            return e;
        end
        if (mode[d] != 0) begin
            e.busy  = 1'b1;
            e.stall = 1'b1;
            nw = seq_len(d, mode[d]) - 1;
            if (kk[d] <= nw) begin
                e.we    = 1'b1;
                e.flush = (kk[d] == 1);
                if (mode[d] == 2) begin
                    e.addr = 12'h300;
                    e.data = mret_mstatus(mstatus);
                end else if (kk[d] == 1) begin
                    e.addr = 12'h341;
                    e.data = l_epc[d];
                end else if (kk[d] == 2) begin
                    e.addr = 12'h342;
                    e.data = l_cause[d];
                end else if (kk[d] == nw) begin
                    e.addr = 12'h300;
                    e.data = trap_mstatus(mstatus, l_priv[d]);
                end else begin
                    e.addr = 12'h343;
                    e.data = l_tval[d];
                end
            end else begin
                e.rv  = 1'b1;
                e.rpc = l_target[d];
            end
        end else if (trap_req) begin
            e.tack = 1'b1;
        end else if (mret_req) begin
            e.mack = 1'b1;
        end else if (csr_wr_req) begin
            e.we     = 1'b1;
            e.addr   = csr_wr_addr;
            e.data   = csr_wr_data;
            e.wr_ack = 1'b1;
        end
        return e;
    endfunction

    task automatic model_commit();
        for (int d = 0; d < NDUT; d++) begin
            if (rst_n !== 1'b1) begin
                mode[d]   = 0;
                kk[d]     = 0;
                priv_m[d] = 2'b11;
            end else if (mode[d] != 0) begin
                if (mode[d] == 2 && kk[d] == 1) priv_m[d] = 2'((mstatus >> 11) & 64'h3);
                if (kk[d] == seq_len(d, mode[d])) begin
                    if (mode[d] == 1) priv_m[d] = 2'b11;
                    mode[d] = 0;
                end else begin
                    kk[d] = kk[d] + 1;
                end
            end else if (trap_req) begin
                mode[d]     = 1;
                kk[d]       = 1;
                l_epc[d]    = trap_pc & ~64'h3;
                l_cause[d]  = trap_cause;
                l_tval[d]   = trap_tval;
                l_priv[d]   = privilege;
                l_target[d] = target_of(d != 1, mtvec, trap_cause);
            end else if (mret_req) begin
                mode[d]     = 2;
                kk[d]       = 1;
                l_target[d] = mepc;
            end
        end
    endtask

    // Called right after a falling edge with inputs already applied
    task automatic check_cycle(string tag);
        obs_t e;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            e = expect_of(d);
            checks++;
            assert (obs[d] === e) else begin
                errors++;
                $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, d, cyc, obs[d], e);
            end
        end
    endtask

    task automatic chk(string tag, logic [XLEN-1:0] o, logic [XLEN-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    task automatic adv();
        model_commit();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(string tag, int n);
        for (int i = 0; i < n; i++) begin
            check_cycle(tag);
            adv();
        end
    endtask

    task automatic rand_operands();
        trap_cause  = {$urandom, $urandom};
        trap_pc     = {$urandom, $urandom};
        trap_tval   = {$urandom, $urandom};
        privilege   = 2'($urandom_range(0, 3));
        mtvec       = {$urandom, $urandom};
        mepc        = {$urandom, $urandom};
        mstatus     = {$urandom, $urandom};
        csr_wr_addr = 12'($urandom_range(0, 4095));
        csr_wr_data = {$urandom, $urandom};
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            mode[d] = 0; kk[d] = 0; priv_m[d] = 2'b11;
            l_epc[d] = '0; l_cause[d] = '0; l_tval[d] = '0; l_priv[d] = '0; l_target[d] = '0;
        end
        rst_n = 1'b0;
        rand_operands();
        trap_req   = 1'b1;
        mret_req   = 1'b0;
        csr_wr_req = 1'b1;
        @(negedge clk);

        // Reset: requests present but everything quiet, PRIV_OUT=M
        check_cycle("reset");
        chk("reset_priv", 64'(obs[0].priv), 64'h3);
        chk("reset_tack", 64'(obs[0].tack), 64'h0);
        adv();

        // Idle CSR-instruction write passes straight through
        rst_n = 1'b1; trap_req = 1'b0;
        csr_wr_addr = 12'h305; csr_wr_data = 64'h100;
        check_cycle("csr_idle");
        chk("csr_idle_ack", 64'(obs[0].wr_ack), 64'h1);
        chk("csr_idle_addr", 64'(obs[0].addr), 64'h305);
        adv();

        // Exception with a competing CSR write that is held through the sequence
        privilege = 2'b00; trap_cause = 64'h2; trap_pc = 64'h8000_0104;
        trap_tval = 64'h13; mtvec = 64'h8000_0001; mstatus = 64'h8; trap_req = 1'b1;
        check_cycle("exc_accept");
        chk("arb_trap_ack", 64'(obs[0].tack), 64'h1);
        chk("arb_csr_ack", 64'(obs[0].wr_ack), 64'h0);
        adv();
        trap_req = 1'b0;
        check_cycle("exc_n1");
        chk("exc_epc_addr", 64'(obs[0].addr), 64'h341);
        chk("exc_epc_data", obs[0].data, 64'h8000_0104);
        chk("exc_flush", 64'(obs[0].flush), 64'h1);
        chk("busy_csr_ack", 64'(obs[0].wr_ack), 64'h0);
        adv();
        check_cycle("exc_n2");
        chk("exc_cause_addr", 64'(obs[0].addr), 64'h342);
        chk("exc_cause_data", obs[0].data, 64'h2);
        adv();
        check_cycle("exc_n3");
        chk("exc_tval_addr", 64'(obs[0].addr), 64'h343);
        chk("exc_tval_data", obs[0].data, 64'h13);
        chk("notval_status", obs[2].data, 64'h80);
        adv();
        check_cycle("exc_n4");
        chk("exc_status_addr", 64'(obs[0].addr), 64'h300);
        chk("exc_status_data", obs[0].data, 64'h80);
        chk("notval_redirect", 64'(obs[2].rv), 64'h1);
        adv();
        check_cycle("exc_n5");
        chk("exc_redirect_v", 64'(obs[0].rv), 64'h1);
        chk("exc_redirect_pc", obs[0].rpc, 64'h8000_0000);
        chk("notval_grant", 64'(obs[2].wr_ack), 64'h1);
        adv();
        check_cycle("exc_n6");
        chk("exc_priv", 64'(obs[0].priv), 64'h3);
        chk("exc_grant", 64'(obs[0].wr_ack), 64'h1);
        adv();
        csr_wr_req = 1'b0;
        run("exc_tail", 1);

        // Interrupt into a vectored mtvec
        trap_cause = 64'h8000_0000_0000_0007; trap_req = 1'b1;
        check_cycle("irq_accept");
        adv();
        trap_req = 1'b0;
        run("irq_seq", 4);
        check_cycle("irq_n5");
        chk("irq_vectored_pc", obs[0].rpc, 64'h8000_001C);
        chk("irq_direct_pc", obs[1].rpc, 64'h8000_0000);
        adv();
        run("irq_tail", 2);

        // MRET back to S-mode
        mstatus = 64'h880; mepc = 64'h400; mret_req = 1'b1;
        check_cycle("mret_accept");
        chk("mret_ack", 64'(obs[0].mack), 64'h1);
        adv();
        mret_req = 1'b0;
        check_cycle("mret_n1");
        chk("mret_status_addr", 64'(obs[0].addr), 64'h300);
        chk("mret_status_data", obs[0].data, 64'h88);
        adv();
        check_cycle("mret_n2");
        chk("mret_redirect_pc", obs[0].rpc, 64'h400);
        chk("mret_priv", 64'(obs[0].priv), 64'h1);
        adv();
        run("mret_tail", 2);

        // Reset in the middle of a trap, request held so it restarts
        mstatus = 64'h8; trap_req = 1'b1;
        check_cycle("rst_accept");
        adv();
        check_cycle("rst_n1");
        adv();
        rst_n = 1'b0;
        check_cycle("rst_mid");
        chk("rst_mid_we", 64'(obs[0].we), 64'h0);
        chk("rst_mid_priv", 64'(obs[0].priv), 64'h3);
        adv();
        check_cycle("rst_hold");
        adv();
        rst_n = 1'b1;
        check_cycle("rst_restart");
        chk("rst_restart_ack", 64'(obs[0].tack), 64'h1);
        adv();
        trap_req = 1'b0;
        run("rst_seq", 7);

        // Randomized traffic, including requests during busy and reset pulses
        for (int i = 0; i < 400; i++) begin
            rand_operands();
            trap_req   = ($urandom_range(0, 99) < 12);
            mret_req   = ($urandom_range(0, 99) < 10);
            csr_wr_req = ($urandom_range(0, 99) < 50);
            rst_n      = ($urandom_range(0, 199) != 0);
            check_cycle("rand");
            adv();
        end
        rst_n = 1'b1; trap_req = 1'b0; mret_req = 1'b0; csr_wr_req = 1'b0;
        run("drain", 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
